// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the iterative multiply sequencer.
package cpu_pkg;

  localparam int unsigned MULT_DWIDTH = 32;
  localparam int unsigned MULT_ITERS  = MULT_DWIDTH;
  localparam int unsigned MULT_CNT_W  = $clog2(MULT_ITERS);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } mult_state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Control-unit / datapath handshake bundle for the multiply sequencer.
interface mult_seq_ctrl_if
  import cpu_pkg::*;
#(
  parameter int unsigned DWIDTH = MULT_DWIDTH
);

  logic              start;
  logic              is_signed;
  logic [DWIDTH-1:0] op_a;
  logic [DWIDTH-1:0] op_b;
  logic              rd_req;
  logic [DWIDTH-1:0] hi;
  logic [DWIDTH-1:0] lo;
  logic              busy;
  logic              stall;
  logic              done;

  // Control unit side.
  modport master (
    output start, is_signed, op_a, op_b, rd_req,
    input  hi, lo, busy, stall, done
  );

  // Sequencer side.
  modport slave (
    input  start, is_signed, op_a, op_b, rd_req,
    output hi, lo, busy, stall, done
  );

endinterface

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: accumulator, multiplier and multiplicand registers.
module mult_shift_add #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                step_i,
  input  logic                clear_i,
  input  logic [DWIDTH-1:0]   mcand_i,
  input  logic [DWIDTH-1:0]   mplier_i,
  output logic [2*DWIDTH-1:0] prod_o
);

  logic [DWIDTH:0]   acc_q, acc_d;
  logic [DWIDTH-1:0] mplier_q, mplier_d;
  logic [DWIDTH-1:0] mcand_q;
  logic [DWIDTH-1:0] addend;
  logic [DWIDTH:0]   sum;

  // One add-shift step: conditional add, then shift {acc, mplier} right as one value.
  always_comb begin
    addend             = mplier_q[0] ? mcand_q : '0;
    sum                = acc_q + {1'b0, addend};
    {acc_d, mplier_d}  = {1'b0, sum, mplier_q[DWIDTH-1:1]};
  end

  // Operand/accumulator registers with load, step and clear controls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else if (clear_i) begin
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
    end else if (load_i) begin
      acc_q    <= '0;
      mplier_q <= mplier_i;
      mcand_q  <= mcand_i;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  // After the final shift the top accumulator bit is always zero.
  assign prod_o = {acc_q[DWIDTH-1:0], mplier_q};

endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative multiply sequencer: FSM, iteration counter, sign fixup, HI/LO and PC stall.
module mult_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DWIDTH = MULT_DWIDTH
) (
  input logic           clk,
  input logic           reset,
  mult_seq_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(DWIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DWIDTH - 1);

  mult_state_t         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [DWIDTH-1:0]   hi_q, hi_d;
  logic [DWIDTH-1:0]   lo_q, lo_d;
  logic                done_q, done_d;

  logic                load, step, clear;
  logic [DWIDTH-1:0]   mag_a, mag_b;
  logic [2*DWIDTH-1:0] prod_raw, prod_fix;
  logic                busy;

  // Magnitudes only for signed mult; |most negative| is itself as an unsigned value.
  always_comb begin
    mag_a = (bus.is_signed && bus.op_a[DWIDTH-1]) ? -bus.op_a : bus.op_a;
    mag_b = (bus.is_signed && bus.op_b[DWIDTH-1]) ? -bus.op_b : bus.op_b;
  end

  mult_shift_add #(
    .DWIDTH (DWIDTH)
  ) u_shift_add (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (load),
    .step_i   (step),
    .clear_i  (clear),
    .mcand_i  (mag_a),
    .mplier_i (mag_b),
    .prod_o   (prod_raw)
  );

  assign prod_fix = neg_q ? -prod_raw : prod_raw;

  // Next-state, counter, sign latch and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          load    = 1'b1;
          neg_d   = bus.is_signed & (bus.op_a[DWIDTH-1] ^ bus.op_b[DWIDTH-1]);
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end
      end
      StFix: begin
        hi_d    = prod_fix[2*DWIDTH-1:DWIDTH];
        lo_d    = prod_fix[DWIDTH-1:0];
        done_d  = 1'b1;
        // Product is captured this edge; drop the stale operands.
        clear   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset discards any partial result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Stall is combinational so it settles before the PC edge.
  always_comb begin
    busy      = (state_q != StIdle);
    bus.busy  = busy;
    bus.stall = busy & (bus.start | bus.rd_req);
    bus.done  = done_q;
    bus.hi    = hi_q;
    bus.lo    = lo_q;
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: behavioural model plus directed vectors.
module tb_mult_seq_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic cmp_en;

  mult_seq_ctrl_if #(.DWIDTH(32)) bus ();

  mult_seq_ctrl #(
    .DWIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a mult is a 33-cycle busy window ending with the exact 64-bit product.
  int          m_left;
  logic [63:0] m_pend;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_done;

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_pend <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_hi, m_lo} <= m_pend;
          m_done       <= 1'b1;
        end
      end else if (bus.start) begin
        m_left <= 33;
        m_pend <= model_prod(bus.op_a, bus.op_b, bus.is_signed);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", bus.busy, (m_left > 0));
      chk("cyc_stall", bus.stall, (m_left > 0) && (bus.start || bus.rd_req));
      chk("cyc_done", bus.done, m_done);
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Issue one mult at E0 and observe the following 40 cycles.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int busy_cnt, output int done_cnt);
    bus.start     = 1'b1;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.is_signed = s;
    after_edge();
    bus.start = 1'b0;
    busy_cnt  = 0;
    done_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      after_edge();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int bc;
    int dc;
    int stall_cnt;
    int done_k;

    total         = 0;
    bad           = 0;
    cmp_en        = 1'b0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.rd_req    = 1'b0;
    #1 reset = 1'b0;

    // Reset state, with start and rd_req asserted to show stall stays low.
    after_edge();
    after_edge();
    bus.start  = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_done", bus.done, 0);
    bus.start  = 1'b0;
    bus.rd_req = 1'b0;
    after_edge();
    reset  = 1'b1;
    cmp_en = 1'b1;
    after_edge();

    // multu 3 x 5
    run_mult(32'd3, 32'd5, 1'b0, bc, dc);
    chk("u3x5_busy_cycles", bc, 33);
    chk("u3x5_done_pulses", dc, 1);
    chk("u3x5_hi", bus.hi, 32'h0000_0000);
    chk("u3x5_lo", bus.lo, 32'h0000_000F);
    chk("model_u3x5_lo", m_lo, 32'h0000_000F);

    // mult -2 x 3
    run_mult(32'hFFFF_FFFE, 32'd3, 1'b1, bc, dc);
    chk("s_m2x3_hi", bus.hi, 32'hFFFF_FFFF);
    chk("s_m2x3_lo", bus.lo, 32'hFFFF_FFFA);
    chk("model_s_m2x3_lo", m_lo, 32'hFFFF_FFFA);

    // mult most-negative squared
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, bc, dc);
    chk("s_min_sq_hi", bus.hi, 32'h4000_0000);
    chk("s_min_sq_lo", bus.lo, 32'h0000_0000);

    // multu all-ones squared
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc, dc);
    chk("u_ones_hi", bus.hi, 32'hFFFF_FFFE);
    chk("u_ones_lo", bus.lo, 32'h0000_0001);
    chk("model_u_ones_hi", m_hi, 32'hFFFF_FFFE);

    // mult -1 x -1
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, bc, dc);
    chk("s_ones_hi", bus.hi, 32'h0000_0000);
    chk("s_ones_lo", bus.lo, 32'h0000_0001);
    chk("s_ones_done_pulses", dc, 1);

    // mfhi right after a mult: stalls 33 cycles then sees the new result
    bus.start     = 1'b1;
    bus.op_a      = 32'h0001_0000;
    bus.op_b      = 32'h0003_0000;
    bus.is_signed = 1'b0;
    after_edge();
    bus.start  = 1'b0;
    bus.rd_req = 1'b1;
    #1;
    stall_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.stall) stall_cnt++;
      else break;
      after_edge();
    end
    chk("rd_stall_cycles", stall_cnt, 33);
    chk("rd_hi_after", bus.hi, 32'h0000_0003);
    chk("rd_lo_after", bus.lo, 32'h0000_0000);
    chk("rd_done_after", bus.done, 1);
    after_edge();
    chk("rd_idle_no_stall", bus.stall, 0);
    bus.rd_req = 1'b0;
    after_edge();

    // Back-to-back: second start held from E5, accepted at E34, written at E67
    bus.start     = 1'b1;
    bus.op_a      = 32'd2;
    bus.op_b      = 32'd2;
    bus.is_signed = 1'b0;
    after_edge();
    bus.start = 1'b0;
    stall_cnt = 0;
    done_k    = -1;
    for (int k = 1; k <= 70; k++) begin
      after_edge();
      if (k == 5) begin
        bus.start = 1'b1;
        bus.op_a  = 32'd6;
        bus.op_b  = 32'd7;
        #1;
      end
      if (k < 34 && bus.stall) stall_cnt++;
      if (k == 33) begin
        chk("b2b_first_idle", bus.busy, 0);
        chk("b2b_first_lo", bus.lo, 32'd4);
      end
      if (k == 34) begin
        chk("b2b_second_accepted", bus.busy, 1);
        bus.start = 1'b0;
      end
      if (k > 34 && bus.done && done_k < 0) done_k = k;
    end
    chk("b2b_stall_cycles", stall_cnt, 28);
    chk("b2b_done_edge", done_k, 67);
    chk("b2b_second_lo", bus.lo, 32'd42);
    chk("b2b_second_hi", bus.hi, 32'd0);

    // Reset mid-CALC discards the partial result
    bus.start = 1'b1;
    bus.op_a  = 32'h0000_1234;
    bus.op_b  = 32'h0000_0010;
    after_edge();
    bus.start = 1'b0;
    repeat (10) after_edge();
    chk("pre_rst_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    chk("mid_rst_done", bus.done, 0);
    after_edge();
    reset = 1'b1;
    after_edge();
    run_mult(32'd7, 32'd7, 1'b0, bc, dc);
    chk("post_rst_lo", bus.lo, 32'd49);
    chk("post_rst_hi", bus.hi, 32'd0);
    chk("post_rst_busy_cycles", bc, 33);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
